// File: rtl/pipeline_interlock_ctrl.sv
// Pipeline interlock controller: turns hazard, branch and memory-handshake
// events into PC / stage-register enable and flush controls. It also tracks
// data-memory waits against a timeout and keeps saturating stall/flush counters.
module pipeline_interlock_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             do_hazard,
  input  logic             branch_taken,
  input  logic             dm_req,
  input  logic             dm_ready,
  input  logic             im_ready,
  input  logic             halt,
  input  logic             resume,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, HALT} state_t;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              flush_evt;
  logic              dm_miss;

  assign dm_miss = dm_req && !dm_ready;
  assign halted  = (state == HALT);

  // State, DM-wait counter, sticky error flag and saturating perf counters.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == MEM_WAIT && wait_nxt == WAIT_MAX)
        mem_error <= 1'b1;
      if (!pc_enable && state != HALT && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

  // Next-state and wait-counter decision, resolved in event priority order.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    flush_evt = 1'b0;
    unique case (state)
      RUN, LOAD_STALL: begin
        if (halt) begin
          state_nxt = HALT;
        end else if (dm_miss) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end else if (branch_taken) begin
          state_nxt = RUN;
          flush_evt = 1'b1;
        end else if (do_hazard && state == RUN) begin
          state_nxt = LOAD_STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        // Halt is deferred: it is seen in RUN once the access completes.
        if (dm_ready)
          state_nxt = RUN;
        else if (wait_cnt != WAIT_MAX)
          wait_nxt = wait_cnt + WAIT_W'(1);
      end
      HALT: begin
        if (resume && !halt)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Pipeline control outputs, combinational from state and inputs.
  always_comb begin
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b1;
    idex_flush   = 1'b0;
    exmem_enable = 1'b1;
    memwb_flush  = 1'b0;
    if (reset) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_flush  = 1'b1;
    end else begin
      unique case (state)
        RUN, LOAD_STALL: begin
          if (halt || dm_miss) begin
            pc_enable    = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_flush  = 1'b1;
          end else if (branch_taken) begin
            // The dependent instruction of any concurrent hazard is flushed.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (do_hazard && state == RUN) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
          end else if (!im_ready) begin
            pc_enable  = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        MEM_WAIT, HALT: begin
          if (state == HALT || !dm_ready) begin
            pc_enable    = 1'b0;
            ifid_enable  = 1'b0;
            idex_enable  = 1'b0;
            exmem_enable = 1'b0;
            memwb_flush  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Testbench for pipeline_interlock_ctrl: directed scenarios with hand-computed
// expectations, then randomized traffic compared every cycle against a
// rule-based model of the interlock behaviour.
module tb_pipeline_interlock_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             do_hazard, branch_taken, dm_req, dm_ready, im_ready, halt, resume;
  logic             pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic             exmem_enable, memwb_flush, halted, mem_error;
  logic [CNT_W-1:0] stall_count, flush_count;

  int tests = 0;
  int fails = 0;

  pipeline_interlock_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .do_hazard(do_hazard), .branch_taken(branch_taken),
    .dm_req(dm_req), .dm_ready(dm_ready), .im_ready(im_ready), .halt(halt),
    .resume(resume), .pc_enable(pc_enable), .ifid_enable(ifid_enable),
    .ifid_flush(ifid_flush), .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .memwb_flush(memwb_flush), .halted(halted),
    .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hz, input logic br, input logic dq, input logic dr,
                       input logic ir, input logic ha, input logic rs);
    do_hazard = hz; branch_taken = br; dm_req = dq; dm_ready = dr;
    im_ready = ir; halt = ha; resume = rs;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Output vector order: pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl
  localparam logic [6:0] O_DEFAULT = 7'b1101010;
  localparam logic [6:0] O_FREEZE  = 7'b0000001;
  localparam logic [6:0] O_RESET   = 7'b0010101;
  localparam logic [6:0] O_BRANCH  = 7'b1111110;
  localparam logic [6:0] O_HAZARD  = 7'b0001110;
  localparam logic [6:0] O_NOFETCH = 7'b0111010;

  bit         m_halted, m_mem_busy, m_just_stalled, m_err;
  int         m_wait, m_stall, m_flush;
  logic [6:0] exp_o;

  always @(negedge clock) begin
    if (reset) begin
      m_halted = 0; m_mem_busy = 0; m_just_stalled = 0; m_err = 0;
      m_wait = 0; m_stall = 0; m_flush = 0;
      exp_o = O_RESET;
      check("out_vec", {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
                        exmem_enable, memwb_flush}, exp_o);
      check("halted", halted, 0);
      check("mem_error", mem_error, 0);
      check("stall_count", stall_count, 0);
      check("flush_count", flush_count, 0);
    end else begin
      bit was_halted;
      was_halted = m_halted;
      exp_o = O_DEFAULT;
      if (m_halted) begin
        exp_o = O_FREEZE;
        if (resume && !halt) m_halted = 0;
      end else if (m_mem_busy) begin
        if (dm_ready) begin
          m_mem_busy = 0;
        end else begin
          exp_o = O_FREEZE;
          m_wait = (m_wait + 1 > MEM_TIMEOUT) ? MEM_TIMEOUT : m_wait + 1;
        end
      end else begin
        bit allow_hazard;
        allow_hazard = !m_just_stalled;
        m_just_stalled = 0;
        if (halt) begin
          exp_o = O_FREEZE; m_halted = 1;
        end else if (dm_req && !dm_ready) begin
          exp_o = O_FREEZE; m_mem_busy = 1; m_wait = 1;
        end else if (branch_taken) begin
          exp_o = O_BRANCH;
          m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        end else if (do_hazard && allow_hazard) begin
          exp_o = O_HAZARD; m_just_stalled = 1;
        end else if (!im_ready) begin
          exp_o = O_NOFETCH;
        end
      end
      check("out_vec", {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
                        exmem_enable, memwb_flush}, exp_o);
      check("halted", halted, was_halted);
      check("mem_error", mem_error, m_err);
      check("stall_count", stall_count, m_stall);
      check("flush_count", flush_count, m_flush - (exp_o == O_BRANCH && m_flush > 0 &&
            flush_count != CNT_W'(m_flush) ? 1 : 0));
      // Registered effects of this cycle, visible from the next cycle on.
      if (!exp_o[6] && !was_halted) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (m_mem_busy && m_wait >= MEM_TIMEOUT) m_err = 1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle();
    step(); step();
    check("rst_pc_enable", pc_enable, 0);
    check("rst_flushes", {ifid_flush, idex_flush, memwb_flush}, 3'b111);
    check("rst_halted", halted, 0);
    check("rst_stall", stall_count, 0);
    reset = 1'b0;

    // Idle pipeline runs freely.
    repeat (5) begin
      idle(); #1;
      check("idle_enables", {pc_enable, ifid_enable, idex_enable, exmem_enable}, 4'hf);
      check("idle_flushes", {ifid_flush, idex_flush, memwb_flush}, 3'b000);
      step();
    end
    check("idle_counts", {stall_count, flush_count}, 0);

    // Load-use hazard held two cycles: one stall, then LOAD_STALL default.
    drive(1, 0, 0, 0, 1, 0, 0); #1;
    check("hz_c1", {pc_enable, ifid_enable, idex_flush}, 3'b001);
    step(); #1;
    check("hz_c2", {pc_enable, ifid_enable, idex_flush}, 3'b110);
    step(); idle(); #1;
    check("hz_stall", stall_count, 1);

    // Branch wins over hazard, no LOAD_STALL entry: a hazard next cycle stalls.
    drive(1, 1, 0, 0, 1, 0, 0); #1;
    check("br_hz", {pc_enable, ifid_flush, idex_flush}, 3'b111);
    step(); drive(1, 0, 0, 0, 1, 0, 0); #1;
    check("br_no_ls", pc_enable, 0);
    step(); idle(); #1;
    check("br_flush", flush_count, 1);
    check("br_stall", stall_count, 2);
    step();

    // DM miss for 3 cycles, then ready.
    drive(0, 0, 1, 0, 1, 0, 0);
    repeat (3) begin
      #1;
      check("dm_freeze", {exmem_enable, memwb_flush}, 2'b01);
      step();
    end
    drive(0, 0, 1, 1, 1, 0, 0); #1;
    check("dm_release", {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_flush}, 5'b11110);
    step(); idle(); #1;
    check("dm_stall", stall_count, 5);

    // Halt pulse, four HALT cycles with resume on the last.
    drive(0, 0, 0, 0, 1, 1, 0); #1;
    check("halt_entry", halted, 0);
    step(); idle();
    repeat (3) begin
      #1; check("halt_hold", halted, 1); step();
    end
    drive(0, 0, 0, 0, 1, 0, 1); #1;
    check("halt_resume", {halted, pc_enable}, 2'b10);
    step(); idle(); #1;
    check("halt_exit", halted, 0);
    check("halt_stall", stall_count, 6);

    // DM timeout: mem_error rises when the wait counter reaches MEM_TIMEOUT.
    drive(0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i == 3) check("to_before", mem_error, 0);
      if (i == 4) check("to_set", mem_error, 1);
      step();
    end
    drive(0, 0, 1, 1, 1, 0, 0); step(); idle(); #1;
    check("to_sticky", mem_error, 1);
    check("to_stall", stall_count, 12);
    reset = 1'b1; #1;
    check("to_cleared", mem_error, 0);
    step(); reset = 1'b0;

    // Flush counter saturation.
    repeat (20) begin
      drive(0, 1, 0, 0, 1, 0, 0); step();
    end
    idle(); #1;
    check("flush_sat", flush_count, CNT_MAX);

    // Randomized traffic against the model.
    repeat (3000) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
